stage_ex: RTL and testbench

- RV32I execute stage. Sits directly downstream of the ID/EX pipeline register and consumes its busa/busb/funct3/imm/op/pc/rd outputs.
- Computes the ALU result, resolves branches and jumps, and registers everything into the EX/MEM pipeline register.
- Shifts run on an area-cheap serial shifter (1 bit/cycle) controlled by a small FSM. While a shift is in progress, `busy` tells the hazard unit to hold the upstream stages.

---
 rtl/rv_pkg.sv | 36 +++
 rtl/ex_serial_shifter.sv | 90 +++++++++
 rtl/stage_ex.sv | 198 +++++++++++++++++++
 tb/tb_stage_ex.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I encodings for the execute stage: opcodes, funct3 codes and
// the serial shifter state encoding.
package rv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        SH_IDLE  = 1'b0,
        SH_SHIFT = 1'b1
    } sh_state_e;

endpackage

// File: rtl/ex_serial_shifter.sv
// Iterative 1-bit/cycle shifter. result_o is the accumulator advanced by one
// more step, so the final step is taken by the consumer in the done cycle.
module ex_serial_shifter
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena_i,
    input  logic            flush_i,
    input  logic            start_i,
    input  logic            dir_right_i,
    input  logic            arith_i,
    input  logic [XLEN-1:0] data_i,
    input  logic [4:0]      shamt_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    sh_state_e       state_q;
    logic [XLEN-1:0] acc_q;
    logic [4:0]      cnt_q;
    logic [XLEN-1:0] step_s;

    // one-bit shift of the accumulator
    always_comb begin
        if (dir_right_i) begin
            step_s = {arith_i & acc_q[XLEN-1], acc_q[XLEN-1:1]};
        end else begin
            step_s = {acc_q[XLEN-2:0], 1'b0};
        end
    end

    assign result_o = step_s;

    // hold request and completion flag
    always_comb begin
        busy_o = 1'b0;
        done_o = 1'b0;
        case (state_q)
            SH_IDLE:  busy_o = start_i;
            SH_SHIFT: begin
                busy_o = (cnt_q > 5'd1);
                done_o = (cnt_q == 5'd1);
            end
            default: begin
                busy_o = 1'b0;
                done_o = 1'b0;
            end
        endcase
    end

    // shifter FSM; flush acts even while the stage is frozen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SH_IDLE;
            acc_q   <= '0;
            cnt_q   <= 5'd0;
        end else if (flush_i) begin
            state_q <= SH_IDLE;
            cnt_q   <= 5'd0;
        end else if (ena_i) begin
            case (state_q)
                SH_IDLE: begin
                    if (start_i) begin
                        acc_q   <= data_i;
                        cnt_q   <= shamt_i;
                        state_q <= SH_SHIFT;
                    end
                end
                SH_SHIFT: begin
                    if (cnt_q > 5'd1) begin
                        acc_q <= step_s;
                        cnt_q <= cnt_q - 5'd1;
                    end else begin
                        cnt_q   <= 5'd0;
                        state_q <= SH_IDLE;
                    end
                end
                default: begin
                    state_q <= SH_IDLE;
                    cnt_q   <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: rtl/stage_ex.sv
// RV32I execute stage: ALU, branch resolution and the EX/MEM pipeline register.
// Non-zero shifts are handed to the serial shifter when SERIAL_SHIFT=1.
module stage_ex
    import rv_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter bit SERIAL_SHIFT = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena_exmem,
    input  logic            flush,
    input  logic [XLEN-1:0] busa_in,
    input  logic [XLEN-1:0] busb_in,
    input  logic [2:0]      funct3_in,
    input  logic [XLEN-1:0] imm_in,
    input  logic [6:0]      op_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            valid_out,
    output logic [XLEN-1:0] result_out,
    output logic [XLEN-1:0] store_data_out,
    output logic [2:0]      funct3_out,
    output logic [6:0]      op_out,
    output logic [4:0]      rd_out,
    output logic            br_taken_out,
    output logic [XLEN-1:0] br_target_out
);

    logic            valid_q, valid_d, taken_q, taken_d;
    logic [XLEN-1:0] result_q, result_d, sdata_q, sdata_d, target_q, target_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [6:0]      op_q, op_d;
    logic [4:0]      rd_q, rd_d;

    logic [XLEN-1:0] op_b_s, alu_s, shift_s, ex_res_s, ex_tgt_s, sh_res_s;
    logic            legal_s, ex_taken_s, is_shift_s, sh_start_s, sh_busy_s, sh_done_s;
    logic            lt_s, ltu_s, eq_s;
    logic [4:0]      shamt_s;

    assign op_b_s     = (op_in == OP_R) ? busb_in : imm_in;
    assign shamt_s    = op_b_s[4:0];
    assign is_shift_s = ((op_in == OP_R) || (op_in == OP_IMM)) &&
                        ((funct3_in == F3_SLL) || (funct3_in == F3_SR));
    assign sh_start_s = SERIAL_SHIFT && is_shift_s && (shamt_s != 5'd0);
    assign lt_s       = ($signed(busa_in) < $signed(op_b_s));
    assign ltu_s      = (busa_in < op_b_s);
    assign eq_s       = (busa_in == op_b_s);

    // with the serial shifter, only shamt=0 reaches the single-cycle path
    always_comb begin
        if (SERIAL_SHIFT) begin
            shift_s = busa_in;
        end else if (funct3_in == F3_SLL) begin
            shift_s = busa_in << shamt_s;
        end else if (imm_in[10]) begin
            shift_s = $signed(busa_in) >>> shamt_s;
        end else begin
            shift_s = busa_in >> shamt_s;
        end
    end

    // ALU
    always_comb begin
        case (funct3_in)
            F3_ADD:  alu_s = ((op_in == OP_R) && imm_in[10]) ? busa_in - op_b_s : busa_in + op_b_s;
            F3_SLT:  alu_s = {{(XLEN-1){1'b0}}, lt_s};
            F3_SLTU: alu_s = {{(XLEN-1){1'b0}}, ltu_s};
            F3_XOR:  alu_s = busa_in ^ op_b_s;
            F3_OR:   alu_s = busa_in | op_b_s;
            F3_AND:  alu_s = busa_in & op_b_s;
            default: alu_s = shift_s;
        endcase
    end

    // per-opcode result, redirect and legality
    always_comb begin
        legal_s    = 1'b1;
        ex_res_s   = '0;
        ex_taken_s = 1'b0;
        ex_tgt_s   = '0;
        case (op_in)
            OP_R, OP_IMM:      ex_res_s = alu_s;
            OP_LUI:            ex_res_s = imm_in;
            OP_AUIPC:          ex_res_s = pc_in + imm_in;
            OP_LOAD, OP_STORE: ex_res_s = busa_in + imm_in;
            OP_JAL: begin
                ex_res_s   = pc_in + XLEN'(4);
                ex_taken_s = 1'b1;
                ex_tgt_s   = pc_in + imm_in;
            end
            OP_JALR: begin
                ex_res_s   = pc_in + XLEN'(4);
                ex_taken_s = 1'b1;
                ex_tgt_s   = (busa_in + imm_in) & ~XLEN'(1);
            end
            OP_BRANCH: begin
                ex_tgt_s = pc_in + imm_in;
                case (funct3_in)
                    F3_BEQ:  ex_taken_s = (busa_in == busb_in);
                    F3_BNE:  ex_taken_s = (busa_in != busb_in);
                    F3_BLT:  ex_taken_s = ($signed(busa_in) < $signed(busb_in));
                    F3_BGE:  ex_taken_s = !($signed(busa_in) < $signed(busb_in));
                    F3_BLTU: ex_taken_s = (busa_in < busb_in);
                    F3_BGEU: ex_taken_s = !(busa_in < busb_in);
                    default: ex_taken_s = 1'b0;
                endcase
            end
            default: legal_s = 1'b0;
        endcase
    end

    ex_serial_shifter #(.XLEN(XLEN)) u_shifter (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena_i       (ena_exmem),
        .flush_i     (flush),
        .start_i     (sh_start_s),
        .dir_right_i (funct3_in == F3_SR),
        .arith_i     (imm_in[10]),
        .data_i      (busa_in),
        .shamt_i     (shamt_s),
        .busy_o      (sh_busy_s),
        .done_o      (sh_done_s),
        .result_o    (sh_res_s)
    );

    assign busy = rst_n && !flush && sh_busy_s;

    // EX/MEM next state: bubble unless a real instruction completes this cycle
    always_comb begin
        valid_d  = 1'b0;
        result_d = '0;
        sdata_d  = '0;
        funct3_d = 3'd0;
        op_d     = 7'd0;
        rd_d     = 5'd0;
        taken_d  = 1'b0;
        target_d = '0;
        if (flush) begin
            valid_d = 1'b0;
        end else if (!ena_exmem) begin
            valid_d  = valid_q;
            result_d = result_q;
            sdata_d  = sdata_q;
            funct3_d = funct3_q;
            op_d     = op_q;
            rd_d     = rd_q;
            taken_d  = taken_q;
            target_d = target_q;
        end else if (sh_done_s || (!sh_busy_s && legal_s)) begin
            valid_d  = 1'b1;
            result_d = sh_done_s ? sh_res_s : ex_res_s;
            sdata_d  = busb_in;
            funct3_d = funct3_in;
            op_d     = op_in;
            rd_d     = rd_in;
            taken_d  = sh_done_s ? 1'b0 : ex_taken_s;
            target_d = sh_done_s ? '0 : ex_tgt_s;
        end else begin
            valid_d = 1'b0;
        end
    end

    // EX/MEM pipeline register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            sdata_q  <= '0;
            funct3_q <= 3'd0;
            op_q     <= 7'd0;
            rd_q     <= 5'd0;
            taken_q  <= 1'b0;
            target_q <= '0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            sdata_q  <= sdata_d;
            funct3_q <= funct3_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            taken_q  <= taken_d;
            target_q <= target_d;
        end
    end

    assign valid_out      = valid_q;
    assign result_out     = result_q;
    assign store_data_out = sdata_q;
    assign funct3_out     = funct3_q;
    assign op_out         = op_q;
    assign rd_out         = rd_q;
    assign br_taken_out   = taken_q;
    assign br_target_out  = target_q;

endmodule

// File: tb/tb_stage_ex.sv
// Self-checking bench for stage_ex: directed cases plus randomized instructions
// checked against an instruction-level reference model.
module tb_stage_ex;

    logic        clk = 1'b0;
    logic        rst_n, ena_exmem, flush;
    logic [31:0] busa_in, busb_in, imm_in, pc_in;
    logic [2:0]  funct3_in;
    logic [6:0]  op_in;
    logic [4:0]  rd_in;
    logic        busy, valid_out, br_taken_out;
    logic [31:0] result_out, store_data_out, br_target_out;
    logic [2:0]  funct3_out;
    logic [6:0]  op_out;
    logic [4:0]  rd_out;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic        v;
        logic [31:0] res;
        logic        tk;
        logic [31:0] tgt;
    } exp_t;

    stage_ex dut (
        .clk(clk), .rst_n(rst_n), .ena_exmem(ena_exmem), .flush(flush),
        .busa_in(busa_in), .busb_in(busb_in), .funct3_in(funct3_in),
        .imm_in(imm_in), .op_in(op_in), .pc_in(pc_in), .rd_in(rd_in),
        .busy(busy), .valid_out(valid_out), .result_out(result_out),
        .store_data_out(store_data_out), .funct3_out(funct3_out),
        .op_out(op_out), .rd_out(rd_out), .br_taken_out(br_taken_out),
        .br_target_out(br_target_out)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    endtask

    // architectural meaning of one instruction
    function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] imm, input logic [31:0] pc);
        exp_t e;
        logic [31:0] ob;
        int sh;
        e  = '0;
        ob = (op == 7'h33) ? b : imm;
        sh = int'(ob % 32);
        e.v = 1'b1;
        case (op)
            7'h33, 7'h13: case (f3)
                3'd0: e.res = (op == 7'h33 && imm[10]) ? a - ob : a + ob;
                3'd1: e.res = a << sh;
                3'd2: e.res = ($signed(a) < $signed(ob)) ? 32'd1 : 32'd0;
                3'd3: e.res = (a < ob) ? 32'd1 : 32'd0;
                3'd4: e.res = a ^ ob;
                3'd5: e.res = imm[10] ? 32'($signed(a) >>> sh) : a >> sh;
                3'd6: e.res = a | ob;
                default: e.res = a & ob;
            endcase
            7'h37: e.res = imm;
            7'h17: e.res = pc + imm;
            7'h03, 7'h23: e.res = a + imm;
            7'h6F: begin e.res = pc + 32'd4; e.tk = 1'b1; e.tgt = pc + imm; end
            7'h67: begin e.res = pc + 32'd4; e.tk = 1'b1; e.tgt = (a + imm) & 32'hFFFF_FFFE; end
            7'h63: begin
                e.tgt = pc + imm;
                case (f3)
                    3'd0: e.tk = (a == b);
                    3'd1: e.tk = (a != b);
                    3'd4: e.tk = ($signed(a) < $signed(b));
                    3'd5: e.tk = ($signed(a) >= $signed(b));
                    3'd6: e.tk = (a < b);
                    3'd7: e.tk = (a >= b);
                    default: e.tk = 1'b0;
                endcase
            end
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic int shift_len(input logic [6:0] op, input logic [2:0] f3,
                                     input logic [31:0] b, input logic [31:0] imm);
        if ((op == 7'h33 || op == 7'h13) && (f3 == 3'd1 || f3 == 3'd5))
            return int'(((op == 7'h33) ? b : imm) % 32);
        return 0;
    endfunction

    // present one instruction and follow it until it lands in EX/MEM
    task automatic exec(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] imm, input logic [31:0] pc,
                        input logic [4:0] rd);
        exp_t e;
        int n;
        op_in = op; funct3_in = f3; busa_in = a; busb_in = b; imm_in = imm;
        pc_in = pc; rd_in = rd;
        #1;
        e = model(op, f3, a, b, imm, pc);
        n = shift_len(op, f3, b, imm);
        for (int i = 0; i < n; i++) begin
            chk_eq("busy_shift", 32'(busy), 32'd1);
            @(posedge clk); #1;
            chk_eq("bubble_valid", 32'(valid_out), 32'd0);
        end
        chk_eq("busy_low", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk_eq("valid", 32'(valid_out), 32'(e.v));
        chk_eq("op", 32'(op_out), e.v ? 32'(op) : 32'd0);
        chk_eq("taken", 32'(br_taken_out), 32'(e.tk));
        if (e.v) begin
            chk_eq("result", result_out, e.res);
            chk_eq("target", br_target_out, e.tgt);
            chk_eq("sdata", store_data_out, b);
            chk_eq("funct3", 32'(funct3_out), 32'(f3));
            chk_eq("rd", 32'(rd_out), 32'(rd));
        end
    endtask

    initial begin
        logic [6:0] ops [10];
        ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h7F};

        rst_n = 1'b0; ena_exmem = 1'b1; flush = 1'b0;
        busa_in = '0; busb_in = '0; imm_in = '0; pc_in = '0;
        funct3_in = '0; op_in = '0; rd_in = '0;
        #12;
        chk_eq("rst_valid", 32'(valid_out), 32'd0);
        chk_eq("rst_result", result_out, 32'd0);
        chk_eq("rst_op", 32'(op_out), 32'd0);
        chk_eq("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        exec(7'h33, 3'd0, 32'd7, 32'd5, 32'h000, 32'h0, 5'd1);
        chk_eq("add_lit", result_out, 32'd12);
        exec(7'h33, 3'd0, 32'd7, 32'd5, 32'h400, 32'h0, 5'd2);
        chk_eq("sub_lit", result_out, 32'd2);
        exec(7'h63, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 5'd0);
        chk_eq("blt_taken", 32'(br_taken_out), 32'd1);
        chk_eq("blt_target", br_target_out, 32'h120);
        exec(7'h63, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 5'd0);
        chk_eq("bltu_taken", 32'(br_taken_out), 32'd0);
        exec(7'h67, 3'd0, 32'h1001, 32'd0, 32'd2, 32'h40, 5'd1);
        chk_eq("jalr_res", result_out, 32'h44);
        chk_eq("jalr_tgt", br_target_out, 32'h1002);
        exec(7'h13, 3'd5, 32'h8000_0000, 32'd0, 32'h403, 32'h0, 5'd3);
        chk_eq("srai3_lit", result_out, 32'hF000_0000);
        exec(7'h13, 3'd5, 32'h8000_0000, 32'd0, 32'h400, 32'h0, 5'd3);
        chk_eq("srai0_lit", result_out, 32'h8000_0000);

        // stall mid-shift: SLL 1 by 4 with ena_exmem low for two cycles
        op_in = 7'h13; funct3_in = 3'd1; busa_in = 32'd1; imm_in = 32'd4; rd_in = 5'd4;
        #1; chk_eq("stall_busy0", 32'(busy), 32'd1);
        @(posedge clk); #1; chk_eq("stall_bub1", 32'(valid_out), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1; chk_eq("stall_busy3", 32'(busy), 32'd1);
        ena_exmem = 1'b0;
        @(posedge clk); #1; chk_eq("stall_hold_busy", 32'(busy), 32'd1);
        @(posedge clk); #1; chk_eq("stall_hold_valid", 32'(valid_out), 32'd0);
        ena_exmem = 1'b1;
        @(posedge clk); #1;
        chk_eq("stall_pre_valid", 32'(valid_out), 32'd0);
        chk_eq("stall_pre_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk_eq("stall_valid", 32'(valid_out), 32'd1);
        chk_eq("stall_result", result_out, 32'h10);

        // flush mid-shift
        op_in = 7'h13; funct3_in = 3'd1; busa_in = 32'd1; imm_in = 32'd8;
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        #1; chk_eq("flush_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk_eq("flush_valid", 32'(valid_out), 32'd0);
        chk_eq("flush_op", 32'(op_out), 32'd0);
        flush = 1'b0; op_in = 7'h00;
        #1; chk_eq("flush_idle_busy", 32'(busy), 32'd0);
        exec(7'h33, 3'd0, 32'd7, 32'd5, 32'h000, 32'h0, 5'd1);

        // asynchronous reset mid-shift and after a valid jump
        op_in = 7'h13; funct3_in = 3'd1; busa_in = 32'd1; imm_in = 32'd8;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1; chk_eq("rst_mid_busy", 32'(busy), 32'd0);
        chk_eq("rst_mid_valid", 32'(valid_out), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; op_in = 7'h00;
        exec(7'h6F, 3'd0, 32'd0, 32'd0, 32'h80, 32'h200, 5'd1);
        rst_n = 1'b0;
        #2;
        chk_eq("rst_async_valid", 32'(valid_out), 32'd0);
        chk_eq("rst_async_taken", 32'(br_taken_out), 32'd0);
        chk_eq("rst_async_result", result_out, 32'd0);
        chk_eq("rst_async_target", br_target_out, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int t = 0; t < 200; t++) begin
            logic [31:0] ra, rb, ri;
            ra = $urandom; rb = $urandom; ri = $urandom;
            if ($urandom_range(0, 3) == 0) ra = 32'h8000_0000 | (ra & 32'hF);
            exec(ops[$urandom_range(0, 9)], 3'($urandom_range(0, 7)), ra, rb, ri,
                 $urandom & 32'hFFFF_FFFC, 5'($urandom_range(0, 31)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
